// File: rtl/event_counter_bank.sv
// Multi-channel event counter bank with an atomic snapshot that is drained
// one channel per accepted beat over a valid/ready stream.
module event_counter_bank #(
   parameter int WIDTH         = 16,
   parameter int CHANNELS      = 4,
   parameter bit SATURATE      = 1'b0,
   parameter bit CLEAR_ON_SNAP = 1'b0,
   localparam int CW           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [CHANNELS-1:0] inc,
   input  logic [CHANNELS-1:0] clear,
   input  logic                snap_req,
   output logic                busy,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [CW-1:0]       out_chan,
   output logic [WIDTH-1:0]    out_count,
   output logic                out_ovf,
   output logic [CHANNELS-1:0] ovf
);

   localparam logic [WIDTH-1:0] MAX = '1;

   typedef enum logic {IDLE, DRAIN} state_t;

   state_t              state;
   logic [WIDTH-1:0]    count      [CHANNELS];
   logic [WIDTH-1:0]    snap_count [CHANNELS];
   logic [CHANNELS-1:0] snap_ovf;
   logic [CW-1:0]       next_chan;
   logic                capture;

   assign capture   = (state == IDLE) && snap_req;
   assign next_chan = out_chan + CW'(1);

   // Clear wins over increment, but a same-cycle event still counts as the
   // first event of the new period.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < CHANNELS; i++) count[i] <= '0;
         ovf <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (clear[i] || (CLEAR_ON_SNAP && capture)) begin
               count[i] <= {{(WIDTH-1){1'b0}}, inc[i]};
               ovf[i]   <= 1'b0;
            end else if (inc[i]) begin
               if (count[i] != MAX) begin
                  count[i] <= count[i] + WIDTH'(1);
               end else begin
                  ovf[i] <= 1'b1;
                  if (!SATURATE) count[i] <= '0;
               end
            end
         end
      end
   end

   // Capture reads pre-edge counts, so the snapshot excludes this cycle's events.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         out_chan  <= '0;
         out_count <= '0;
         out_ovf   <= 1'b0;
         snap_ovf  <= '0;
         for (int i = 0; i < CHANNELS; i++) snap_count[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (snap_req) begin
                  for (int i = 0; i < CHANNELS; i++) snap_count[i] <= count[i];
                  snap_ovf  <= ovf;
                  out_count <= count[0];
                  out_ovf   <= ovf[0];
                  out_chan  <= '0;
                  busy      <= 1'b1;
                  out_valid <= 1'b1;
                  state     <= DRAIN;
               end
            end
            DRAIN: begin
               if (out_ready) begin
                  if (out_chan == CW'(CHANNELS - 1)) begin
                     busy      <= 1'b0;
                     out_valid <= 1'b0;
                     out_chan  <= '0;
                     state     <= IDLE;
                  end else begin
                     out_chan  <= next_chan;
                     out_count <= snap_count[next_chan];
                     out_ovf   <= snap_ovf[next_chan];
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_event_counter_bank.sv
// Directed bench for event_counter_bank: four instances with different
// parameter sets share one stimulus stream.
module tb_event_counter_bank;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] inc = '0;
   logic [3:0] clear = '0;
   logic       snap_req = 1'b0;
   logic       out_ready = 1'b0;

   logic        d0_busy, d0_valid, d0_ovf_o;
   logic [1:0]  d0_chan;
   logic [15:0] d0_count;
   logic [3:0]  d0_ovf;
   logic        d1_busy, d1_valid, d1_ovf_o;
   logic [1:0]  d1_chan;
   logic [3:0]  d1_count;
   logic [3:0]  d1_ovf;
   logic        d2_busy, d2_valid, d2_ovf_o;
   logic [1:0]  d2_chan;
   logic [3:0]  d2_count;
   logic [3:0]  d2_ovf;
   logic        d3_busy, d3_valid, d3_ovf_o;
   logic [1:0]  d3_chan;
   logic [15:0] d3_count;
   logic [3:0]  d3_ovf;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   event_counter_bank #(.WIDTH(16), .CHANNELS(4), .SATURATE(1'b0), .CLEAR_ON_SNAP(1'b0)) dut0 (
      .clock(clock), .reset_n(reset_n), .inc(inc), .clear(clear), .snap_req(snap_req),
      .busy(d0_busy), .out_valid(d0_valid), .out_ready(out_ready), .out_chan(d0_chan),
      .out_count(d0_count), .out_ovf(d0_ovf_o), .ovf(d0_ovf));
   event_counter_bank #(.WIDTH(4), .CHANNELS(4), .SATURATE(1'b0), .CLEAR_ON_SNAP(1'b0)) dut1 (
      .clock(clock), .reset_n(reset_n), .inc(inc), .clear(clear), .snap_req(snap_req),
      .busy(d1_busy), .out_valid(d1_valid), .out_ready(out_ready), .out_chan(d1_chan),
      .out_count(d1_count), .out_ovf(d1_ovf_o), .ovf(d1_ovf));
   event_counter_bank #(.WIDTH(4), .CHANNELS(4), .SATURATE(1'b1), .CLEAR_ON_SNAP(1'b0)) dut2 (
      .clock(clock), .reset_n(reset_n), .inc(inc), .clear(clear), .snap_req(snap_req),
      .busy(d2_busy), .out_valid(d2_valid), .out_ready(out_ready), .out_chan(d2_chan),
      .out_count(d2_count), .out_ovf(d2_ovf_o), .ovf(d2_ovf));
   event_counter_bank #(.WIDTH(16), .CHANNELS(4), .SATURATE(1'b0), .CLEAR_ON_SNAP(1'b1)) dut3 (
      .clock(clock), .reset_n(reset_n), .inc(inc), .clear(clear), .snap_req(snap_req),
      .busy(d3_busy), .out_valid(d3_valid), .out_ready(out_ready), .out_chan(d3_chan),
      .out_count(d3_count), .out_ovf(d3_ovf_o), .ovf(d3_ovf));

   // Inputs change and outputs are sampled 1ns after each rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse_inc(input int ch, input int n);
      for (int k = 0; k < n; k++) begin
         inc = '0;
         inc[ch] = 1'b1;
         tick();
      end
      inc = '0;
   endtask

   task automatic clear_all();
      clear = '1;
      tick();
      clear = '0;
   endtask

   task automatic snap_once();
      snap_req = 1'b1;
      tick();
      snap_req = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick();
      tick();
      checks++;
      if ({d0_busy, d0_valid, d0_chan, d0_count, d0_ovf_o, d0_ovf} !== 25'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs got busy=%0b valid=%0b chan=%0d count=%0d out_ovf=%0b ovf=%b want all 0",
                  d0_busy, d0_valid, d0_chan, d0_count, d0_ovf_o, d0_ovf);
      end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_basic_snapshot();
      logic [15:0] exp_count [4];
      exp_count = '{16'd5, 16'd0, 16'd3, 16'd0};
      pulse_inc(0, 5);
      pulse_inc(2, 3);
      out_ready = 1'b1;
      snap_once();
      for (int k = 0; k < 4; k++) begin
         checks++;
         if ({d0_busy, d0_valid} !== 2'b11 || d0_chan !== 2'(k) || d0_count !== exp_count[k] || d0_ovf_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_entry%0d got busy=%0b valid=%0b chan=%0d count=%0d ovf=%0b want 1 1 %0d %0d 0",
                     k, d0_busy, d0_valid, d0_chan, d0_count, d0_ovf_o, k, exp_count[k]);
         end
         tick();
      end
      checks++;
      if ({d0_busy, d0_valid} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL basic_done got busy=%0b valid=%0b want 0 0", d0_busy, d0_valid);
      end
   endtask

   task automatic test_overflow();
      clear_all();
      pulse_inc(1, 17);
      checks++;
      if (d1_ovf !== 4'b0010 || d2_ovf !== 4'b0010 || d0_ovf !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL ovf_live got w4wrap=%b w4sat=%b w16=%b want 0010 0010 0000", d1_ovf, d2_ovf, d0_ovf);
      end
      out_ready = 1'b1;
      snap_once();
      tick();
      checks++;
      if (d1_chan !== 2'd1 || d1_count !== 4'd1 || d1_ovf_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ovf_wrap_entry got chan=%0d count=%0d ovf=%0b want 1 1 1", d1_chan, d1_count, d1_ovf_o);
      end
      checks++;
      if (d2_chan !== 2'd1 || d2_count !== 4'd15 || d2_ovf_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ovf_sat_entry got chan=%0d count=%0d ovf=%0b want 1 15 1", d2_chan, d2_count, d2_ovf_o);
      end
      tick();
      tick();
      tick();
      clear = 4'b0010;
      tick();
      clear = '0;
      checks++;
      if (d1_ovf[1] !== 1'b0 || d2_ovf[1] !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ovf_cleared got w4wrap=%0b w4sat=%0b want 0 0", d1_ovf[1], d2_ovf[1]);
      end
      snap_once();
      tick();
      checks++;
      if (d1_count !== 4'd0 || d2_count !== 4'd0 || d1_ovf_o !== 1'b0 || d2_ovf_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ovf_clear_entry got wrap=%0d/%0b sat=%0d/%0b want 0/0 0/0",
                  d1_count, d1_ovf_o, d2_count, d2_ovf_o);
      end
      tick();
      tick();
      tick();
   endtask

   task automatic test_snap_inc_same_cycle();
      clear_all();
      pulse_inc(0, 7);
      out_ready = 1'b1;
      inc = 4'b0001;
      snap_once();
      inc = '0;
      checks++;
      if (d0_count !== 16'd7 || d3_count !== 16'd7) begin
         errors++;
         $display("[TB] FAIL same_cycle_snap got plain=%0d clr_on_snap=%0d want 7 7", d0_count, d3_count);
      end
      tick();
      tick();
      tick();
      tick();
      snap_once();
      checks++;
      if (d0_count !== 16'd8 || d3_count !== 16'd1) begin
         errors++;
         $display("[TB] FAIL same_cycle_live got plain=%0d clr_on_snap=%0d want 8 1", d0_count, d3_count);
      end
      tick();
      tick();
      tick();
      tick();
   endtask

   task automatic test_backpressure();
      clear_all();
      pulse_inc(0, 2);
      pulse_inc(1, 4);
      pulse_inc(2, 1);
      out_ready = 1'b0;
      snap_once();
      tick();
      checks++;
      if (d0_chan !== 2'd0 || d0_count !== 16'd2 || d0_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL bp_hold0 got chan=%0d count=%0d valid=%0b want 0 2 1", d0_chan, d0_count, d0_valid);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         snap_req = 1'b1;
         inc = 4'b0010;
         tick();
         checks++;
         if (d0_chan !== 2'd1 || d0_count !== 16'd4 || d0_valid !== 1'b1 || d0_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_stall%0d got chan=%0d count=%0d valid=%0b busy=%0b want 1 4 1 1",
                     k, d0_chan, d0_count, d0_valid, d0_busy);
         end
      end
      snap_req = 1'b0;
      inc = '0;
      out_ready = 1'b1;
      tick();
      checks++;
      if (d0_chan !== 2'd2 || d0_count !== 16'd1) begin
         errors++;
         $display("[TB] FAIL bp_resume got chan=%0d count=%0d want 2 1", d0_chan, d0_count);
      end
      tick();
      checks++;
      if (d0_chan !== 2'd3 || d0_count !== 16'd0 || d0_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL bp_last got chan=%0d count=%0d valid=%0b want 3 0 1", d0_chan, d0_count, d0_valid);
      end
      snap_req = 1'b1;
      tick();
      snap_req = 1'b0;
      checks++;
      if ({d0_busy, d0_valid} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL bp_final_snap_ignored got busy=%0b valid=%0b want 0 0", d0_busy, d0_valid);
      end
      tick();
      checks++;
      if ({d0_busy, d0_valid} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL bp_no_queue got busy=%0b valid=%0b want 0 0", d0_busy, d0_valid);
      end
   endtask

   task automatic test_clear_inc();
      clear_all();
      pulse_inc(3, 9);
      clear = 4'b1000;
      inc = 4'b1000;
      tick();
      clear = '0;
      inc = '0;
      out_ready = 1'b1;
      snap_once();
      tick();
      tick();
      tick();
      checks++;
      if (d0_chan !== 2'd3 || d0_count !== 16'd1 || d0_ovf_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL clear_inc got chan=%0d count=%0d ovf=%0b want 3 1 0", d0_chan, d0_count, d0_ovf_o);
      end
      tick();
   endtask

   task automatic test_reset_mid_drain();
      pulse_inc(1, 2);
      out_ready = 1'b1;
      snap_once();
      tick();
      tick();
      checks++;
      if (d0_chan !== 2'd2 || d0_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL rst_pre got chan=%0d valid=%0b want 2 1", d0_chan, d0_valid);
      end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({d0_busy, d0_valid} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL rst_async got busy=%0b valid=%0b want 0 0", d0_busy, d0_valid);
      end
      tick();
      reset_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++;
         if ({d0_busy, d0_valid} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL rst_quiet%0d got busy=%0b valid=%0b want 0 0", k, d0_busy, d0_valid);
         end
      end
      pulse_inc(1, 1);
      snap_once();
      tick();
      checks++;
      if (d0_chan !== 2'd1 || d0_count !== 16'd1 || d0_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL rst_fresh got chan=%0d count=%0d valid=%0b want 1 1 1", d0_chan, d0_count, d0_valid);
      end
      tick();
      tick();
      tick();
   endtask

   initial begin
      test_reset();
      test_basic_snapshot();
      test_overflow();
      test_snap_inc_same_cycle();
      test_backpressure();
      test_clear_inc();
      test_reset_mid_drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/event_counter_bank.md
# event_counter_bank

- Parametrised, multi-channel successor to the single free-running event counter.
- Counts per-channel event pulses on one clock. Takes a race-free snapshot of every counter on request and drains it channel by channel over a valid/ready stream.
- Sits between event sources (per-channel strobes) and a monitor or CSR reader. A read never observes a half-updated count.

## Interface
Parameters:
- WIDTH, 16, bits per counter (>= 2)
- CHANNELS, 4, number of independent counters (>= 1)
- SATURATE, 0, 0 = wrap at 2^WIDTH, 1 = hold at 2^WIDTH-1
- CLEAR_ON_SNAP, 0, 1 = counters restart at snapshot

Ports:
- Clocking and reset: single clock `clock`; asynchronous, active-low reset `reset_n`.
- clock  input  1  sole clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- inc  input  CHANNELS  per-channel event strobe, one count per cycle high
- clear  input  CHANNELS  per-channel synchronous clear of count and overflow flag
- snap_req  input  1  single-cycle snapshot request
- busy  output  1  snapshot drain in progress; snap_req ignored
- out_valid  output  1  snapshot entry valid
- out_ready  input  1  consumer accepts entry
- out_chan  output  max(1,$clog2(CHANNELS))  channel index of current entry
- out_count  output  WIDTH  snapshotted count
- out_ovf  output  1  snapshotted overflow flag
- ovf  output  CHANNELS  live sticky overflow flags

## Operation
- Counters and snapshot registers use nonblocking update only. All reads in a cycle see pre-edge values.
- Per channel, per cycle, highest priority first:
  - clear[i]=1: count <= inc[i] (0 or 1), ovf[i] <= 0. A same-cycle event is not lost.
  - inc[i]=1, count < max: count <= count+1.
  - inc[i]=1, count = max, SATURATE=0: count <= 0, ovf[i] <= 1.
  - inc[i]=1, count = max, SATURATE=1: count holds max, ovf[i] <= 1.
  - otherwise: hold.
- FSM states:
  - IDLE: busy=0, out_valid=0. snap_req=1 captures all counts and ovf flags as seen in that cycle, before that cycle's increments, into the snapshot array. Then go to DRAIN with index 0.
  - DRAIN: busy=1, out_valid=1, out_chan=index, out_count/out_ovf from snapshot[index].
    - On out_valid & out_ready: if index = CHANNELS-1, go to IDLE; else index+1.
    - snap_req ignored; no queueing.
- CLEAR_ON_SNAP=1:
  - On the capture cycle, every count <= inc[i] and ovf <= 0. The capture cycle's events belong to the new period.
  - clear[i] in the same cycle gives the same result.
- Counting continues undisturbed during DRAIN; the snapshot array is frozen.
- Reset values: all counts 0, ovf 0, snapshot array 0, state IDLE, busy 0, out_valid 0, out_chan 0, out_count 0, out_ovf 0.
- Reset mid-DRAIN aborts immediately; no partial entry is delivered after reset deasserts.

## Timing
- Counter latency: inc at edge N is visible on the count register after edge N.
- Snapshot latency: snap_req sampled at edge N gives busy=1, out_valid=1, out_chan=0 in cycle N+1.
- Handshake:
  - out_count, out_ovf and out_chan are stable while out_valid & !out_ready.
  - out_valid never drops without an accept.
- Throughput: one entry per cycle with out_ready held high. A full drain takes CHANNELS cycles.
- After the final accept at edge M: busy=0 in cycle M+1, and snap_req is accepted from cycle M+1. A snap_req in cycle M itself is ignored.
- No combinational path from inputs to out_*. Only out_ready gates state advance.

## Test plan
- Reset, then 5 inc pulses on ch0 and 3 on ch2, then snap_req with out_ready=1 -> entries (0,5,0),(1,0,0),(2,3,0),(3,0,0) on 4 consecutive cycles; busy falls after the 4th.
- WIDTH=4, SATURATE=0: 17 incs on ch1 -> count 1, ovf[1]=1. With SATURATE=1 -> count 15, ovf[1]=1. clear[1] -> count 0, ovf 0.
- Same-cycle snap_req and inc on ch0 whose count is 7 -> snapshot reports 7 and live count becomes 8. With CLEAR_ON_SNAP=1, snapshot reports 7 and live count becomes 1.
- out_ready low for 3 cycles mid-drain at index 1 -> entry 1 held stable, no skip. snap_req pulsed during DRAIN is ignored and the snapshot is unchanged.
- clear and inc same cycle on ch3 with count 9 -> count 1.
- reset_n asserted during DRAIN at index 2 -> out_valid and busy drop asynchronously; after release, no out_valid until a new snap_req.
